// File: rtl/wb_stage.sv
// wb_stage: RV64 writeback stage that aligns and extends load results and drives the GPR write port.
// Define WB_COMMIT_CNT_EN to build the 64-bit retired-instruction counter; otherwise commit_cnt is 0.
module wb_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_wen,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_data,
    input  logic            in_is_load,
    input  logic [1:0]      in_ld_size,
    input  logic            in_ld_unsigned,
    input  logic [2:0]      in_ld_offset,
    input  logic            ld_rsp_valid,
    input  logic [XLEN-1:0] ld_rsp_data,
    output logic            rf_wr_en,
    output logic [4:0]      rf_index_rd,
    output logic [XLEN-1:0] rf_data_rd,
    output logic            rf_update,
    output logic [63:0]     commit_cnt
);
    typedef enum logic [1:0] {IDLE, WAIT_LD, COMMIT} state_t;
    state_t state, state_nx;
    logic            h_wen, h_uns, fire;
    logic [4:0]      h_rd;
    logic [1:0]      h_size;
    logic [2:0]      h_off, eff_off;
    logic [XLEN-1:0] sh, ld_val;
    assign in_ready = state != WAIT_LD;
    assign fire     = in_valid && in_ready;
    always_comb begin
        state_nx = state;
        if (state == WAIT_LD)
            state_nx = ld_rsp_valid ? COMMIT : WAIT_LD;
        else
            state_nx = fire ? (in_is_load ? WAIT_LD : COMMIT) : IDLE;
    end
    // Offset bits below the access size are dropped, so misaligned loads read the enclosing field.
    always_comb begin
        eff_off = h_size == 2'd0 ? h_off :
                  h_size == 2'd1 ? {h_off[2:1], 1'b0} :
                  h_size == 2'd2 ? {h_off[2], 2'b00} : 3'd0;
        sh      = ld_rsp_data >> {eff_off, 3'b000};
        ld_val  = h_size == 2'd0 ? {{(XLEN-8){~h_uns & sh[7]}}, sh[7:0]} :
                  h_size == 2'd1 ? {{(XLEN-16){~h_uns & sh[15]}}, sh[15:0]} :
                  h_size == 2'd2 ? {{(XLEN-32){~h_uns & sh[31]}}, sh[31:0]} : sh;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            h_wen       <= 1'b0;
            h_uns       <= 1'b0;
            h_rd        <= '0;
            h_size      <= '0;
            h_off       <= '0;
            rf_update   <= 1'b0;
            rf_wr_en    <= 1'b0;
            rf_index_rd <= '0;
            rf_data_rd  <= '0;
        end else begin
            state     <= state_nx;
            rf_update <= state_nx == COMMIT;
            rf_wr_en  <= 1'b0;
            if (fire) begin
                h_wen  <= in_wen;
                h_uns  <= in_ld_unsigned;
                h_rd   <= in_rd;
                h_size <= in_ld_size;
                h_off  <= in_ld_offset;
            end
            if (state == WAIT_LD && ld_rsp_valid) begin
                rf_wr_en    <= h_wen && h_rd != 5'd0;
                rf_index_rd <= h_rd;
                rf_data_rd  <= ld_val;
            end else if (fire && !in_is_load) begin
                rf_wr_en    <= in_wen && in_rd != 5'd0;
                rf_index_rd <= in_rd;
                rf_data_rd  <= in_data;
            end
        end
    end
`ifdef WB_COMMIT_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            commit_cnt <= '0;
        else if (state == COMMIT)
            commit_cnt <= commit_cnt + 64'd1;
    end
`else
    assign commit_cnt = 64'd0;
`endif
endmodule
